// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the multi-cycle control unit: opcodes, ALU codes,
// FSM states and the datapath select encodings.
package rv32i_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;
    localparam logic       SRCB_RS2  = 1'b0;
    localparam logic       SRCB_IMM  = 1'b1;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic PCSEL_PC4 = 1'b0;
    localparam logic PCSEL_ALU = 1'b1;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM_WAIT  = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_ILLEGAL
    } op_class_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] inst);
        return inst[6:0];
    endfunction

endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// Control-unit <-> datapath bundle. master = control unit, slave = datapath.
interface multi_cycle_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      iInst_Code;
    logic             iMem_Ready;
    logic             iBr_Taken;

    logic             oIR_En;
    logic             oPC_En;
    logic             oPC_Sel;
    logic [2:0]       oFunct3;
    logic [3:0]       oALU_Control;
    logic [1:0]       oALUSrcA_Sel;
    logic             oALUSrcB_Sel;
    logic [1:0]       oRegWrDataSel;
    logic             oRegWrEn;
    logic             oData_WrEn;
    logic             oData_RdEn;
    logic             oIllegal;
    logic             oBus_Err;
    logic [2:0]       oState;
    logic [CNT_W-1:0] oRetired;

    modport master (
        input  iInst_Code, iMem_Ready, iBr_Taken,
        output oIR_En, oPC_En, oPC_Sel, oFunct3, oALU_Control,
               oALUSrcA_Sel, oALUSrcB_Sel, oRegWrDataSel,
               oRegWrEn, oData_WrEn, oData_RdEn,
               oIllegal, oBus_Err, oState, oRetired
    );

    modport slave (
        output iInst_Code, iMem_Ready, iBr_Taken,
        input  oIR_En, oPC_En, oPC_Sel, oFunct3, oALU_Control,
               oALUSrcA_Sel, oALUSrcB_Sel, oRegWrDataSel,
               oRegWrEn, oData_WrEn, oData_RdEn,
               oIllegal, oBus_Err, oState, oRetired
    );

endinterface

// File: rtl/inst_decoder.sv
// Purely combinational RV32I opcode classifier and ALU/operand-select decode.
module inst_decoder
    import rv32i_pkg::*;
(
    input  logic [31:0] i_inst,
    output op_class_e   o_op_class,
    output logic        o_legal,
    output logic [3:0]  o_alu_ctrl,
    output logic [1:0]  o_src_a,
    output logic        o_src_b,
    output logic [1:0]  o_wr_sel,
    output logic        o_pc_sel_wb
);
    logic [2:0] w_funct3;
    logic       w_funct7_b5;
    logic       w_unused_bits;

    assign w_funct3      = i_inst[14:12];
    assign w_funct7_b5   = i_inst[30];
    assign w_unused_bits = ^{i_inst[31], i_inst[29:15], i_inst[11:7]};

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        o_op_class  = OP_ILLEGAL;
        o_alu_ctrl  = ALU_ADD;
        o_src_a     = SRCA_RS1;
        o_src_b     = SRCB_IMM;
        o_wr_sel    = WB_ALU;
        o_pc_sel_wb = PCSEL_PC4;
        case (opcode_of(i_inst))
            OPC_R: begin
                o_op_class = OP_R;
                o_alu_ctrl = {w_funct7_b5, w_funct3};
                o_src_b    = SRCB_RS2;
            end
            OPC_IALU: begin
                // Only the shift-right immediates use bit 30 (SRLI vs SRAI).
                o_op_class = OP_IALU;
                o_alu_ctrl = {(w_funct3 == 3'b101) ? w_funct7_b5 : 1'b0, w_funct3};
            end
            OPC_LOAD: begin
                o_op_class = OP_LOAD;
                o_wr_sel   = WB_MEM;
            end
            OPC_STORE:  o_op_class = OP_STORE;
            OPC_BRANCH: o_op_class = OP_BRANCH;
            OPC_LUI: begin
                o_op_class = OP_LUI;
                o_src_a    = SRCA_ZERO;
            end
            OPC_AUIPC: begin
                o_op_class = OP_AUIPC;
                o_src_a    = SRCA_PC;
            end
            OPC_JAL: begin
                o_op_class  = OP_JAL;
                o_src_a     = SRCA_PC;
                o_wr_sel    = WB_PC4;
                o_pc_sel_wb = PCSEL_ALU;
            end
            OPC_JALR: begin
                o_op_class  = OP_JALR;
                o_wr_sel    = WB_PC4;
                o_pc_sel_wb = PCSEL_ALU;
            end
            default: ;
        endcase
    end

    assign o_legal = (o_op_class != OP_ILLEGAL);

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// watches memory latency, counts retired instructions and latches traps.
module multi_cycle_control_unit
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                      iClk,
    input  logic                      iRst_n,
    multi_cycle_control_unit_if.master bus
);
    localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 5) ? $clog2(MEM_TIMEOUT + 1) : 5;

    state_e            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_illegal;
    logic              r_bus_err;
    logic [CNT_W-1:0]  r_retired;

    op_class_e         w_op_class;
    logic              w_legal;
    logic [3:0]        w_dec_alu;
    logic [1:0]        w_dec_src_a;
    logic              w_dec_src_b;
    logic [1:0]        w_dec_wr_sel;
    logic              w_dec_pc_sel_wb;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_in_flight;

    logic              w_ir_en;
    logic              w_pc_en;
    logic              w_pc_sel;
    logic [3:0]        w_alu_ctrl;
    logic [1:0]        w_src_a;
    logic              w_src_b;
    logic [1:0]        w_wr_sel;
    logic              w_reg_wr_en;
    logic              w_data_wr_en;
    logic              w_data_rd_en;

    inst_decoder u_inst_decoder (
        .i_inst      (bus.iInst_Code),
        .o_op_class  (w_op_class),
        .o_legal     (w_legal),
        .o_alu_ctrl  (w_dec_alu),
        .o_src_a     (w_dec_src_a),
        .o_src_b     (w_dec_src_b),
        .o_wr_sel    (w_dec_wr_sel),
        .o_pc_sel_wb (w_dec_pc_sel_wb)
    );

    assign w_wait_nxt = r_wait_cnt + WAIT_W'(1);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state    <= ST_FETCH;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
            r_retired  <= '0;
        end else begin
            if (w_pc_en) r_retired <= r_retired + CNT_W'(1);
            case (r_state)
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    if (w_legal) begin
                        r_state <= ST_EXECUTE;
                    end else begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    case (w_op_class)
                        OP_LOAD, OP_STORE: begin
                            r_state    <= ST_MEM_WAIT;
                            r_wait_cnt <= '0;
                        end
                        OP_BRANCH: r_state <= ST_FETCH;
                        default:   r_state <= ST_WRITEBACK;
                    endcase
                end
                ST_MEM_WAIT: begin
                    // Ready is checked first so it wins over a coincident timeout.
                    if (bus.iMem_Ready) begin
                        r_state <= (w_op_class == OP_STORE) ? ST_FETCH : ST_WRITEBACK;
                    end else if (w_wait_nxt == WAIT_W'(MEM_TIMEOUT)) begin
                        r_state   <= ST_TRAP;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_wait_nxt;
                    end
                end
                ST_WRITEBACK: r_state <= ST_FETCH;
                ST_TRAP:      r_state <= ST_TRAP;
                default:      r_state <= ST_FETCH;
            endcase
        end
    end

    assign w_in_flight = (r_state == ST_DECODE)   || (r_state == ST_EXECUTE) ||
                         (r_state == ST_MEM_WAIT) || (r_state == ST_WRITEBACK);

    // Branch and memory-ready decisions must act in the same cycle, so outputs
    // are decoded from the current state plus live inputs.
    always_comb begin
        w_ir_en      = 1'b0;
        w_pc_en      = 1'b0;
        w_pc_sel     = PCSEL_PC4;
        w_alu_ctrl   = ALU_ADD;
        w_src_a      = SRCA_RS1;
        w_src_b      = SRCB_RS2;
        w_wr_sel     = WB_ALU;
        w_reg_wr_en  = 1'b0;
        w_data_wr_en = 1'b0;
        w_data_rd_en = 1'b0;
        if (w_in_flight) begin
            w_alu_ctrl = w_dec_alu;
            w_src_a    = w_dec_src_a;
            w_src_b    = w_dec_src_b;
        end
        case (r_state)
            ST_FETCH: w_ir_en = 1'b1;
            ST_EXECUTE: begin
                if (w_op_class == OP_BRANCH) begin
                    w_pc_en  = 1'b1;
                    w_pc_sel = bus.iBr_Taken;
                    w_src_a  = SRCA_PC;
                    w_src_b  = SRCB_IMM;
                end
            end
            ST_MEM_WAIT: begin
                if (w_op_class == OP_STORE) begin
                    w_data_wr_en = 1'b1;
                    w_pc_en      = bus.iMem_Ready;
                end else if (w_op_class == OP_LOAD) begin
                    w_data_rd_en = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                w_reg_wr_en = 1'b1;
                w_pc_en     = 1'b1;
                w_wr_sel    = w_dec_wr_sel;
                w_pc_sel    = w_dec_pc_sel_wb;
            end
            default: ;
        endcase
    end

    assign bus.oIR_En        = w_ir_en;
    assign bus.oPC_En        = w_pc_en;
    assign bus.oPC_Sel       = w_pc_sel;
    assign bus.oFunct3       = bus.iInst_Code[14:12];
    assign bus.oALU_Control  = w_alu_ctrl;
    assign bus.oALUSrcA_Sel  = w_src_a;
    assign bus.oALUSrcB_Sel  = w_src_b;
    assign bus.oRegWrDataSel = w_wr_sel;
    assign bus.oRegWrEn      = w_reg_wr_en;
    assign bus.oData_WrEn    = w_data_wr_en;
    assign bus.oData_RdEn    = w_data_rd_en;
    assign bus.oIllegal      = r_illegal;
    assign bus.oBus_Err      = r_bus_err;
    assign bus.oState        = r_state;
    assign bus.oRetired      = r_retired;

endmodule
